seg_display_scanner: RTL and testbench

// - Downstream of the countdown commander: consumes its BCD time fields (min/sec/ms_10), digit-select

---
 rtl/seg_pkg.sv | 37 +++
 rtl/bcd_to_seg.sv | 28 ++
 rtl/seg_display_scanner.sv | 142 ++++++++++++++
 tb/tb_seg_display_scanner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants and edit-field codes.
// Used by the display scanner and the countdown commander.
package seg_pkg;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] TGT_MS   = 2'b00;
  localparam logic [1:0] TGT_SEC  = 2'b01;
  localparam logic [1:0] TGT_MIN  = 2'b10;
  localparam logic [1:0] TGT_NONE = 2'b11;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] ms_10;
    logic [1:0] target;
    logic       time_out;
  } snap_t;

  // Field code owning a digit position: 0-1 ms, 2-3 sec, 4-5 min
  function automatic logic [1:0] field_of(logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-high 7-segment pattern.
// Non-decimal nibbles show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  // Pure lookup; default covers 10-15 so the output is never X
  always_comb begin
    pat = SEG_DASH;
    case (nib)
      4'd0: pat = SEG_0;
      4'd1: pat = SEG_1;
      4'd2: pat = SEG_2;
      4'd3: pat = SEG_3;
      4'd4: pat = SEG_4;
      4'd5: pat = SEG_5;
      4'd6: pat = SEG_6;
      4'd7: pat = SEG_7;
      4'd8: pat = SEG_8;
      4'd9: pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// 6-digit multiplexed MM.SS.hh display driver with
// edit-field blink and time-out flash.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_HZ       = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [7:0] ms_10_i,
  input  logic [1:0] target_i,
  input  logic       time_out_i,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DWELL  = CLK_HZ / (SCAN_HZ * 6);
  localparam int HALF   = CLK_HZ / (2 * BLINK_HZ);
  localparam int DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HF_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
  localparam logic [HF_W-1:0] HF_LAST = HF_W'(HALF - 1);
  localparam logic POL = (SEG_ACTIVE_LOW != 0);

  generate
    if (DWELL < 1 || HALF < 1) begin : g_bad_cfg
      $error("seg_display_scanner: DWELL or blink half-period < 1");
    end
  endgenerate

  logic [DW_W-1:0] dwell_cnt, dwell_n;
  logic [HF_W-1:0] blink_cnt, blink_n;
  logic            vis, vis_n;
  logic [2:0]      idx, idx_n;
  logic            started, started_n;
  snap_t           snap, snap_n, live;

  logic            tick, wrap, restart;
  logic [3:0]      nib;
  logic [6:0]      pat;
  logic            blank_dig, blank_dp, dp_pos;
  logic [5:0]      an_hi;
  logic [6:0]      seg_hi;
  logic            dp_hi;

  assign live = '{min: min_i, sec: sec_i, ms_10: ms_10_i,
                  target: target_i, time_out: time_out_i};

  // Next-state: dwell/scan index, frame snapshot, blink phase
  always_comb begin
    tick      = (dwell_cnt == DW_LAST);
    dwell_n   = tick ? '0 : dwell_cnt + 1'b1;
    started_n = started;
    idx_n     = idx;
    wrap      = tick && (!started || idx == 3'd5);
    if (tick) begin
      started_n = 1'b1;
      idx_n     = wrap ? 3'd0 : idx + 3'd1;
    end
    snap_n  = wrap ? live : snap;
    restart = wrap &&
              ((live.target != snap.target) ||
               (live.time_out && !snap.time_out));
    if (restart) begin
      blink_n = '0;
      vis_n   = 1'b1;
    end else if (blink_cnt == HF_LAST) begin
      blink_n = '0;
      vis_n   = ~vis;
    end else begin
      blink_n = blink_cnt + 1'b1;
      vis_n   = vis;
    end
  end

  // Digit mux, blanking and active-high levels from next state
  always_comb begin
    nib = snap_n.ms_10[3:0];
    unique case (idx_n)
      3'd0:    nib = snap_n.ms_10[3:0];
      3'd1:    nib = snap_n.ms_10[7:4];
      3'd2:    nib = snap_n.sec[3:0];
      3'd3:    nib = snap_n.sec[7:4];
      3'd4:    nib = snap_n.min[3:0];
      3'd5:    nib = snap_n.min[7:4];
      default: nib = snap_n.ms_10[3:0];
    endcase
    dp_pos    = (idx_n == 3'd2) || (idx_n == 3'd4);
    blank_dp  = !vis_n && snap_n.time_out;
    blank_dig = !vis_n &&
                (snap_n.time_out ||
                 (snap_n.target != TGT_NONE &&
                  field_of(idx_n) == snap_n.target));
    an_hi  = started_n ? (6'b000001 << idx_n) : 6'b000000;
    seg_hi = (started_n && !blank_dig) ? pat : SEG_BLANK;
    dp_hi  = started_n && dp_pos && !blank_dp;
  end

  bcd_to_seg u_dec (
    .nib (nib),
    .pat (pat)
  );

  // Scanner state registers
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      blink_cnt <= '0;
      vis       <= 1'b1;
      idx       <= 3'd0;
      started   <= 1'b0;
      snap      <= '0;
    end else begin
      dwell_cnt <= dwell_n;
      blink_cnt <= blink_n;
      vis       <= vis_n;
      idx       <= idx_n;
      started   <= started_n;
      snap      <= snap_n;
    end
  end

  // Output registers; polarity applied here only
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      an  <= {6{POL}};
      seg <= {7{POL}};
      dp  <= POL;
    end else begin
      an  <= an_hi ^ {6{POL}};
      seg <= seg_hi ^ {7{POL}};
      dp  <= dp_hi ^ POL;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner, checking an
// active-low and an active-high build side by side.
module tb_seg_display_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] min_i, sec_i, ms_10_i;
  logic [1:0] target_i;
  logic       time_out_i;
  logic [5:0] an, an_h;
  logic [6:0] seg, seg_h;
  logic       dp, dp_h;
  int         total = 0;
  int         bad = 0;
  int         ecnt;

  localparam logic [13:0] DARK = 14'h3FFF;

  seg_display_scanner #(
    .CLK_HZ(600), .SCAN_HZ(10), .BLINK_HZ(5), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk_core(clk), .rst(rst), .min_i(min_i), .sec_i(sec_i),
    .ms_10_i(ms_10_i), .target_i(target_i),
    .time_out_i(time_out_i), .an(an), .seg(seg), .dp(dp)
  );

  seg_display_scanner #(
    .CLK_HZ(600), .SCAN_HZ(10), .BLINK_HZ(5), .SEG_ACTIVE_LOW(0)
  ) dut_h (
    .clk_core(clk), .rst(rst), .min_i(min_i), .sec_i(sec_i),
    .ms_10_i(ms_10_i), .target_i(target_i),
    .time_out_i(time_out_i), .an(an_h), .seg(seg_h), .dp(dp_h)
  );

  always #5 clk = ~clk;

  // Posedges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // Active-low {an,seg,dp} for a lit digit
  function automatic logic [13:0] lit(int d, logic [6:0] p,
                                      logic dpon);
    logic [5:0] a;
    a = 6'b000001 << d;
    return ~{a, p, dpon};
  endfunction

  task automatic chk(string tag, logic [13:0] exp);
    total++;
    assert ({an, seg, dp} === exp) else begin
      bad++;
      $error("FAIL %s low got=%h exp=%h", tag, {an, seg, dp}, exp);
    end
    total++;
    assert ({an_h, seg_h, dp_h} === ~exp) else begin
      bad++;
      $error("FAIL %s high got=%h exp=%h", tag,
             {an_h, seg_h, dp_h}, ~exp);
    end
  endtask

  // Sample at the negedge after posedge e
  task automatic step_to(int e);
    int guard;
    guard = 0;
    while (ecnt < e && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (ecnt != e) begin
      total++;
      bad++;
      $error("FAIL step_to got=%0d exp=%0d", ecnt, e);
    end
  endtask

  initial begin
    logic [6:0] fr [6];
    fr = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    min_i = 8'h12; sec_i = 8'h34; ms_10_i = 8'h56;
    target_i = 2'b11; time_out_i = 1'b0;
    #1 rst = 1'b1;
    #20;
    chk("reset", DARK);
    @(negedge clk);
    rst = 1'b0;
    step_to(9);
    chk("pre_tick", DARK);
    for (int i = 0; i < 6; i++) begin
      step_to(10 + 10 * i);
      chk($sformatf("frame_d%0d", i),
          lit(i, fr[i], (i == 2 || i == 4)));
      step_to(19 + 10 * i);
      chk($sformatf("hold_d%0d", i),
          lit(i, fr[i], (i == 2 || i == 4)));
    end
    step_to(70);
    chk("f2_d0", lit(0, 7'h7D, 1'b0));
    step_to(75);
    target_i = 2'b01;
    step_to(150);
    chk("sec_vis", lit(2, 7'h66, 1'b1));
    step_to(210);
    chk("sec_off_d2", lit(2, 7'h00, 1'b1));
    step_to(220);
    chk("sec_off_d3", lit(3, 7'h00, 1'b0));
    step_to(230);
    chk("min_steady", lit(4, 7'h5B, 1'b1));
    step_to(270);
    chk("sec_back", lit(2, 7'h66, 1'b1));
    step_to(320);
    target_i = 2'b10;
    step_to(330);
    chk("old_tgt_off", lit(2, 7'h00, 1'b1));
    step_to(410);
    chk("min_vis_new", lit(4, 7'h5B, 1'b1));
    step_to(450);
    chk("sec_vis_tmin", lit(2, 7'h66, 1'b1));
    step_to(470);
    chk("min_off", lit(4, 7'h00, 1'b1));
    step_to(500);
    target_i = 2'b00;
    step_to(550);
    chk("restart_vis", lit(0, 7'h7D, 1'b0));
    step_to(610);
    chk("ms_off", lit(0, 7'h00, 1'b0));
    step_to(620);
    time_out_i = 1'b1;
    step_to(750);
    chk("to_off_d2", lit(2, 7'h00, 1'b0));
    step_to(770);
    chk("to_off_d4", lit(4, 7'h00, 1'b0));
    step_to(810);
    chk("to_on_d2", lit(2, 7'h66, 1'b1));
    step_to(820);
    time_out_i = 1'b0;
    target_i = 2'b11;
    step_to(855);
    sec_i = 8'h3A;
    min_i = 8'h99;
    step_to(870);
    chk("tear_d2", lit(2, 7'h66, 1'b1));
    step_to(890);
    chk("tear_d4", lit(4, 7'h5B, 1'b1));
    step_to(930);
    chk("dash", lit(2, 7'h40, 1'b1));
    step_to(940);
    chk("sec_tens", lit(3, 7'h4F, 1'b0));
    step_to(950);
    chk("min_9", lit(4, 7'h6F, 1'b1));
    step_to(1003);
    rst = 1'b1;
    #1;
    chk("rst_mid", DARK);
    @(negedge clk);
    rst = 1'b0;
    step_to(9);
    chk("post_rst_dark", DARK);
    step_to(10);
    chk("post_rst_d0", lit(0, 7'h7D, 1'b0));
    step_to(20);
    chk("post_rst_d1", lit(1, 7'h6D, 1'b0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
